// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the two-master firmware RAM/MMIO arbiter:
//   - FSM state encoding (IDLE -> BUSY -> RESP -> IDLE)
//   - one-hot grant codes {m1,m0}
//   - default read data returned on a watchdog-terminated access
//   - pickGrant helper that resolves which master wins a request
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arbState_t;

    localparam int GRANT_W = 2;

    localparam logic [GRANT_W-1:0] GRANT_NONE = 2'b00;
    localparam logic [GRANT_W-1:0] GRANT_M0   = 2'b01;
    localparam logic [GRANT_W-1:0] GRANT_M1   = 2'b10;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    // m1 wins when it is the only requester, or when both request and the
    // caller says m1 is preferred. Only meaningful when at least one is valid.
    function automatic logic [GRANT_W-1:0] pickGrant(input logic m0Valid,
                                                     input logic m1Valid,
                                                     input logic preferM1);
        if (m1Valid && (!m0Valid || preferM1)) begin
            return GRANT_M1;
        end
        return GRANT_M0;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the two native-bus masters (picorv32 semantics), the shared slave
// port and the arbiter status lines.
// Modports:
//   arbiter : the mem_arbiter block itself
//   master  : the requesting side (m0 core, m1 DMA/loader) plus err_clr,
//             sees ready/rdata, grant and timeout_err
//   slave   : the RAM/MMIO decode side, sees s_* request, returns s_ready/s_rdata
// Parameters: ADDR_W address width, DATA_W data width (strobes DATA_W/8).
// ---------------------------------------------------------------------------
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              m0_valid;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [STRB_W-1:0] m0_wstrb;
    logic              m0_ready;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_valid;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [STRB_W-1:0] m1_wstrb;
    logic              m1_ready;
    logic [DATA_W-1:0] m1_rdata;

    logic              s_valid;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic [STRB_W-1:0] s_wstrb;
    logic              s_ready;
    logic [DATA_W-1:0] s_rdata;

    logic [GRANT_W-1:0] grant;
    logic               timeout_err;
    logic               err_clr;

    modport arbiter (
        input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
        output m0_ready, m0_rdata,
        input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
        output m1_ready, m1_rdata,
        output s_valid, s_addr, s_wdata, s_wstrb,
        input  s_ready, s_rdata,
        output grant, timeout_err,
        input  err_clr
    );

    modport master (
        output m0_valid, m0_addr, m0_wdata, m0_wstrb,
        input  m0_ready, m0_rdata,
        output m1_valid, m1_addr, m1_wdata, m1_wstrb,
        input  m1_ready, m1_rdata,
        input  grant, timeout_err,
        output err_clr
    );

    modport slave (
        input  s_valid, s_addr, s_wdata, s_wstrb,
        output s_ready, s_rdata
    );

endinterface

// File: rtl/mem_arbiter_watchdog.sv
// ---------------------------------------------------------------------------
// mem_arbiter_watchdog
// Saturating cycle counter used to terminate slave accesses that never
// complete. Counts from 0 while enabled and raises o_expired once the count
// reaches TIMEOUT_CYCLES-1, i.e. on the TIMEOUT_CYCLES-th enabled cycle.
// Ports:
//   clk, reset : clock / asynchronous active-high reset
//   i_clear    : force the count back to 0 (has priority over i_enable)
//   i_enable   : advance the count by one per cycle
//   o_expired  : count has reached TIMEOUT_CYCLES-1
// ---------------------------------------------------------------------------
module mem_arbiter_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] r_count;

    // Counter holds at the terminal value so o_expired stays stable until the
    // owner clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Two-master arbiter sharing the firmware RAM/MMIO slave between the
// picorv32 core (m0) and a second native-bus requester (m1). One
// transaction at a time: IDLE -> BUSY -> RESP -> IDLE, minimum 3 cycles.
// A watchdog ends BUSY after TIMEOUT_CYCLES cycles without s_ready, returning
// ERR_RDATA and setting the sticky timeout_err flag.
// Configuration macro:
//   ARB_FIXED_PRIO_EN defined   : m0 always wins simultaneous requests
//   ARB_FIXED_PRIO_EN undefined : round-robin using the last granted master
// Ports:
//   clk, reset : clock / asynchronous active-high reset
//   bus        : mem_arbiter_if.arbiter (m0_*, m1_*, s_*, grant,
//                timeout_err, err_clr)
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                TIMEOUT_CYCLES = 16,
    parameter logic [DATA_W-1:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    mem_arbiter_if.arbiter  bus
);
    localparam int STRB_W = DATA_W / 8;

    arbState_t          r_state;
    logic [GRANT_W-1:0] r_grant;
    logic               r_sValid;
    logic               r_m0Ready;
    logic               r_m1Ready;
    logic [DATA_W-1:0]  r_m0Rdata;
    logic [DATA_W-1:0]  r_m1Rdata;
    logic               r_timeoutErr;

    logic               w_anyValid;
    logic               w_preferM1;
    logic [GRANT_W-1:0] w_winner;
    logic               w_wdExpired;
    logic               w_finish;
    logic [DATA_W-1:0]  w_respData;
    logic [ADDR_W-1:0]  w_sAddr;
    logic [DATA_W-1:0]  w_sWdata;
    logic [STRB_W-1:0]  w_sWstrb;

    assign w_anyValid = bus.m0_valid | bus.m1_valid;
    assign w_winner   = pickGrant(bus.m0_valid, bus.m1_valid, w_preferM1);

`ifdef ARB_FIXED_PRIO_EN
    assign w_preferM1 = 1'b0;
`else
    logic [GRANT_W-1:0] r_lastGrant;

    // Remember who was granted last so a simultaneous request goes to the
    // other master. Starts as m1 so the core wins the first tie after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lastGrant <= GRANT_M1;
        end else if (r_state == ST_IDLE && w_anyValid) begin
            r_lastGrant <= w_winner;
        end
    end

    assign w_preferM1 = (r_lastGrant == GRANT_M0);
`endif

    mem_arbiter_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (r_state != ST_BUSY),
        .i_enable  (r_state == ST_BUSY),
        .o_expired (w_wdExpired)
    );

    // A real s_ready on the last watchdog cycle beats the timeout.
    assign w_finish   = bus.s_ready | w_wdExpired;
    assign w_respData = bus.s_ready ? bus.s_rdata : ERR_RDATA;

    // Slave request fields follow the granted master combinationally.
    assign w_sAddr  = r_grant[1] ? bus.m1_addr  : bus.m0_addr;
    assign w_sWdata = r_grant[1] ? bus.m1_wdata : bus.m0_wdata;
    assign w_sWstrb = r_grant[1] ? bus.m1_wstrb : bus.m0_wstrb;

    // Main transaction FSM with registered handshake outputs. err_clr is
    // applied first so a timeout in the same cycle overrides it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= GRANT_NONE;
            r_sValid     <= 1'b0;
            r_m0Ready    <= 1'b0;
            r_m1Ready    <= 1'b0;
            r_m0Rdata    <= '0;
            r_m1Rdata    <= '0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_m0Ready <= 1'b0;
            r_m1Ready <= 1'b0;
            if (bus.err_clr) begin
                r_timeoutErr <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_anyValid) begin
                        r_grant  <= w_winner;
                        r_sValid <= 1'b1;
                        r_state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_finish) begin
                        if (r_grant[1]) begin
                            r_m1Ready <= 1'b1;
                            r_m1Rdata <= w_respData;
                        end else begin
                            r_m0Ready <= 1'b1;
                            r_m0Rdata <= w_respData;
                        end
                        if (!bus.s_ready) begin
                            r_timeoutErr <= 1'b1;
                        end
                        r_sValid <= 1'b0;
                        r_state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_grant <= GRANT_NONE;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_grant  <= GRANT_NONE;
                    r_sValid <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.s_valid     = r_sValid;
    assign bus.s_addr      = w_sAddr;
    assign bus.s_wdata     = w_sWdata;
    assign bus.s_wstrb     = w_sWstrb;
    assign bus.m0_ready    = r_m0Ready;
    assign bus.m0_rdata    = r_m0Rdata;
    assign bus.m1_ready    = r_m1Ready;
    assign bus.m1_rdata    = r_m1Rdata;
    assign bus.grant       = r_grant;
    assign bus.timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed testbench for mem_arbiter. Each scenario task drives the masters
// and plays the slave by hand, comparing outputs one cycle at a time against
// hand-computed values. Honours ARB_FIXED_PRIO_EN for the tie-break order.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Step to just after the next rising edge; all driving and sampling
    // happens here, safely away from the edge itself.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges with every bus input idle.
    task automatic applyReset;
        reset        = 1'b1;
        bus.m0_valid = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_wstrb = '0;
        bus.m1_valid = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_wstrb = '0;
        bus.s_ready  = 1'b0; bus.s_rdata = '0;
        bus.err_clr  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.m0_valid = 1'b0; bus.m1_valid = 1'b0;
        bus.s_ready = 1'b0; bus.err_clr = 1'b0;
        tick();
        checks++; if (bus.s_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_s_valid got=%0h exp=0", bus.s_valid); end
        checks++; if (bus.grant !== 2'b00) begin failures++; $display("[TB] FAIL reset_grant got=%0h exp=0", bus.grant); end
        checks++; if ({bus.m1_ready, bus.m0_ready} !== 2'b00) begin failures++; $display("[TB] FAIL reset_ready got=%0h exp=0", {bus.m1_ready, bus.m0_ready}); end
        checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_timeout_err got=%0h exp=0", bus.timeout_err); end
        checks++; if (bus.m0_rdata !== 32'h0 || bus.m1_rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata got=%0h/%0h exp=0/0", bus.m0_rdata, bus.m1_rdata); end
        applyReset();
    endtask

    task automatic test_single_read;
        bus.m0_valid = 1'b1; bus.m0_addr = 32'h0000_0010; bus.m0_wstrb = 4'h0;
        tick();
        checks++; if (bus.s_valid !== 1'b1) begin failures++; $display("[TB] FAIL rd_s_valid got=%0h exp=1", bus.s_valid); end
        checks++; if (bus.grant !== 2'b01) begin failures++; $display("[TB] FAIL rd_grant got=%0h exp=1", bus.grant); end
        checks++; if (bus.s_addr !== 32'h0000_0010) begin failures++; $display("[TB] FAIL rd_s_addr got=%0h exp=10", bus.s_addr); end
        checks++; if (bus.m0_ready !== 1'b0) begin failures++; $display("[TB] FAIL rd_early_ready got=%0h exp=0", bus.m0_ready); end
        bus.s_ready = 1'b1; bus.s_rdata = 32'h1234_5678;
        tick();
        bus.s_ready = 1'b0;
        checks++; if (bus.m0_ready !== 1'b1) begin failures++; $display("[TB] FAIL rd_m0_ready got=%0h exp=1", bus.m0_ready); end
        checks++; if (bus.m0_rdata !== 32'h1234_5678) begin failures++; $display("[TB] FAIL rd_m0_rdata got=%0h exp=12345678", bus.m0_rdata); end
        checks++; if (bus.s_valid !== 1'b0) begin failures++; $display("[TB] FAIL rd_resp_s_valid got=%0h exp=0", bus.s_valid); end
        bus.m0_valid = 1'b0;
        tick();
        checks++; if (bus.m0_ready !== 1'b0 || bus.grant !== 2'b00) begin failures++; $display("[TB] FAIL rd_idle got ready=%0h grant=%0h exp 0/0", bus.m0_ready, bus.grant); end
    endtask

    // Both masters hold valid continuously, so each returns to IDLE with a
    // fresh tie. Round-robin alternates; fixed priority keeps picking m0.
    task automatic test_round_robin;
        logic [1:0]  expG [3];
        logic [31:0] rd;
        logic [31:0] gotData;
`ifdef ARB_FIXED_PRIO_EN
        expG = '{2'b01, 2'b01, 2'b01};
`else
        expG = '{2'b01, 2'b10, 2'b01};
`endif
        applyReset();
        bus.m0_addr = 32'h0000_0100; bus.m0_wstrb = 4'h0;
        bus.m1_addr = 32'h0000_0200; bus.m1_wstrb = 4'h0;
        bus.m0_valid = 1'b1; bus.m1_valid = 1'b1;
        for (int r = 0; r < 3; r++) begin
            tick();
            checks++; if (bus.grant !== expG[r]) begin failures++; $display("[TB] FAIL rr_grant[%0d] got=%0h exp=%0h", r, bus.grant, expG[r]); end
            checks++; if (bus.s_addr !== (expG[r] == 2'b10 ? 32'h0000_0200 : 32'h0000_0100)) begin failures++; $display("[TB] FAIL rr_s_addr[%0d] got=%0h", r, bus.s_addr); end
            rd = 32'hA000_0000 + 32'(r);
            bus.s_ready = 1'b1; bus.s_rdata = rd;
            tick();
            bus.s_ready = 1'b0;
            checks++; if ({bus.m1_ready, bus.m0_ready} !== expG[r]) begin failures++; $display("[TB] FAIL rr_ready[%0d] got=%0h exp=%0h", r, {bus.m1_ready, bus.m0_ready}, expG[r]); end
            gotData = expG[r][1] ? bus.m1_rdata : bus.m0_rdata;
            checks++; if (gotData !== rd) begin failures++; $display("[TB] FAIL rr_rdata[%0d] got=%0h exp=%0h", r, gotData, rd); end
            if (r == 2) begin
                bus.m0_valid = 1'b0; bus.m1_valid = 1'b0;
            end
            tick();
            checks++; if (bus.grant !== 2'b00) begin failures++; $display("[TB] FAIL rr_idle_grant[%0d] got=%0h exp=0", r, bus.grant); end
        end
    endtask

    task automatic test_m1_write;
        bus.m0_valid = 1'b0; bus.m0_addr = 32'hFFFF_FFF0; bus.m0_wdata = 32'h1111_1111; bus.m0_wstrb = 4'h1;
        bus.m1_valid = 1'b1; bus.m1_addr = 32'h1000_0000; bus.m1_wdata = 32'hCAFE_F00D; bus.m1_wstrb = 4'hF;
        tick();
        checks++; if (bus.grant !== 2'b10) begin failures++; $display("[TB] FAIL wr_grant got=%0h exp=2", bus.grant); end
        checks++; if (bus.s_valid !== 1'b1 || bus.s_wstrb !== 4'hF) begin failures++; $display("[TB] FAIL wr_s_valid_wstrb got=%0h/%0h exp=1/f", bus.s_valid, bus.s_wstrb); end
        checks++; if (bus.s_addr !== 32'h1000_0000 || bus.s_wdata !== 32'hCAFE_F00D) begin failures++; $display("[TB] FAIL wr_s_addr_wdata got=%0h/%0h exp=10000000/cafef00d", bus.s_addr, bus.s_wdata); end
        bus.s_ready = 1'b1; bus.s_rdata = 32'h0;
        tick();
        bus.s_ready = 1'b0;
        checks++; if (bus.m1_ready !== 1'b1 || bus.m0_ready !== 1'b0) begin failures++; $display("[TB] FAIL wr_ready got m1=%0h m0=%0h exp 1/0", bus.m1_ready, bus.m0_ready); end
        bus.m1_valid = 1'b0;
        tick();
    endtask

    // Slave stays silent: 16 BUSY cycles, then ERR data and the sticky flag.
    // err_clr is held high on the final BUSY cycle to show the set wins.
    task automatic test_timeout;
        int earlyReady;
        earlyReady = 0;
        bus.m0_valid = 1'b1; bus.m0_addr = 32'h0000_0020; bus.m0_wstrb = 4'h0;
        bus.s_ready = 1'b0;
        tick();
        for (int i = 1; i < 16; i++) begin
            tick();
            if (bus.m0_ready === 1'b1) earlyReady++;
        end
        checks++; if (bus.s_valid !== 1'b1 || earlyReady != 0) begin failures++; $display("[TB] FAIL to_still_busy got s_valid=%0h early=%0d exp 1/0", bus.s_valid, earlyReady); end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        checks++; if (bus.m0_ready !== 1'b1) begin failures++; $display("[TB] FAIL to_m0_ready got=%0h exp=1", bus.m0_ready); end
        checks++; if (bus.m0_rdata !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL to_rdata got=%0h exp=deadbeef", bus.m0_rdata); end
        checks++; if (bus.timeout_err !== 1'b1) begin failures++; $display("[TB] FAIL to_err_set got=%0h exp=1", bus.timeout_err); end
        bus.m0_valid = 1'b0;
        tick();
        checks++; if (bus.timeout_err !== 1'b1) begin failures++; $display("[TB] FAIL to_err_sticky got=%0h exp=1", bus.timeout_err); end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL to_err_clr got=%0h exp=0", bus.timeout_err); end
    endtask

    task automatic test_reset_mid;
        bus.m1_valid = 1'b1; bus.m1_addr = 32'h0000_0300; bus.m1_wstrb = 4'h0;
        tick();
        checks++; if (bus.s_valid !== 1'b1) begin failures++; $display("[TB] FAIL rm_busy got=%0h exp=1", bus.s_valid); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.s_valid !== 1'b0 || bus.grant !== 2'b00) begin failures++; $display("[TB] FAIL rm_async got s_valid=%0h grant=%0h exp 0/0", bus.s_valid, bus.grant); end
        bus.m1_valid = 1'b0;
        tick();
        reset = 1'b0;
        checks++; if (bus.m1_ready !== 1'b0) begin failures++; $display("[TB] FAIL rm_m1_ready got=%0h exp=0", bus.m1_ready); end
        bus.m0_valid = 1'b1; bus.m0_addr = 32'h0000_0040;
        tick();
        checks++; if (bus.grant !== 2'b01) begin failures++; $display("[TB] FAIL rm_next_grant got=%0h exp=1", bus.grant); end
        bus.s_ready = 1'b1; bus.s_rdata = 32'h0BAD_CAFE;
        tick();
        bus.s_ready = 1'b0;
        checks++; if (bus.m0_ready !== 1'b1 || bus.m0_rdata !== 32'h0BAD_CAFE) begin failures++; $display("[TB] FAIL rm_next_resp got ready=%0h data=%0h exp 1/badcafe", bus.m0_ready, bus.m0_rdata); end
        bus.m0_valid = 1'b0;
        tick();
    endtask

    // s_ready arrives on the 16th BUSY cycle, the same one the watchdog fires.
    task automatic test_last_cycle_ready;
        bus.m1_valid = 1'b1; bus.m1_addr = 32'h0000_0400; bus.m1_wstrb = 4'h0;
        bus.s_ready = 1'b0;
        tick();
        for (int i = 1; i < 16; i++) begin
            tick();
        end
        bus.s_ready = 1'b1; bus.s_rdata = 32'h55AA_55AA;
        tick();
        bus.s_ready = 1'b0;
        checks++; if (bus.m1_ready !== 1'b1) begin failures++; $display("[TB] FAIL lc_m1_ready got=%0h exp=1", bus.m1_ready); end
        checks++; if (bus.m1_rdata !== 32'h55AA_55AA) begin failures++; $display("[TB] FAIL lc_rdata got=%0h exp=55aa55aa", bus.m1_rdata); end
        checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL lc_no_err got=%0h exp=0", bus.timeout_err); end
        bus.m1_valid = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout reached without finishing");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_m1_write();
        test_timeout();
        test_reset_mid();
        test_last_cycle_ready();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
